// File: rtl/da_pkg.sv
// Shared constants and FSM state type for the `da` distributed-arithmetic FIR core,
// its tap feeder and their benches.
package da_pkg;

  localparam int NUM_ROMS     = 8;
  localparam int TAPS_PER_ROM = 8;
  localparam int NUM_TAPS     = NUM_ROMS * TAPS_PER_ROM;
  localparam int DA_FRAME_CYC = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/da_tap_feeder_if.sv
// Sample stream into the DA tap feeder.
interface da_tap_feeder_if #(
  parameter int SAMPLE_W = 8
);

  // valid/ready: a sample transfers on a rising clk edge where s_valid && s_ready are
  // both high; while s_valid is high and s_ready low the master holds s_data stable.
  logic [SAMPLE_W-1:0] s_data;
  logic                s_valid;
  logic                s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);

endinterface

// File: rtl/da_tap_line.sv
// 64-tap sample delay line with clear / clear+load, presenting one bit plane of all taps.
module da_tap_line
  import da_pkg::*;
#(
  parameter int SAMPLE_W = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        shift_en,
  input  logic                        clear,
  input  logic [SAMPLE_W-1:0]         load_data,
  input  logic [$clog2(SAMPLE_W)-1:0] bit_sel,
  output logic [NUM_TAPS-1:0]         slice
);

  logic [SAMPLE_W-1:0] taps [NUM_TAPS];

  // clear together with shift_en keeps the new sample in tap 0 and zeroes the rest.
  always_ff @(posedge clk) begin
    if (reset || (clear && !shift_en)) begin
      for (int i = 0; i < NUM_TAPS; i++) taps[i] <= '0;
    end else if (shift_en) begin
      taps[0] <= load_data;
      for (int i = 1; i < NUM_TAPS; i++) taps[i] <= clear ? '0 : taps[i-1];
    end
  end

  always_comb begin
    slice = '0;
    for (int i = 0; i < NUM_TAPS; i++) slice[i] = taps[i][bit_sel];
  end

endmodule

// File: rtl/da_tap_feeder.sv
// Accepts samples into the DA delay line and runs one LSB-first bit-serial address
// sweep per sample, padded so each frame matches the 12-cycle `da` compute frame.
module da_tap_feeder
  import da_pkg::*;
#(
  parameter int SAMPLE_W = 8,
  parameter int GAP_CYC  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear_taps,
  da_tap_feeder_if.slave          s,
  output logic [TAPS_PER_ROM-1:0] A7,
  output logic [TAPS_PER_ROM-1:0] A6,
  output logic [TAPS_PER_ROM-1:0] A5,
  output logic [TAPS_PER_ROM-1:0] A4,
  output logic [TAPS_PER_ROM-1:0] A3,
  output logic [TAPS_PER_ROM-1:0] A2,
  output logic [TAPS_PER_ROM-1:0] A1,
  output logic [TAPS_PER_ROM-1:0] A0,
  output logic                    start,
  output logic                    last_bit,
  output logic                    busy,
  output state_t                  state_dbg
);

  localparam int CNT_W = $clog2(max_int(SAMPLE_W, GAP_CYC));
  localparam int BIT_W = $clog2(SAMPLE_W);
  localparam logic [CNT_W-1:0] LAST_B = CNT_W'(SAMPLE_W - 1);
  localparam logic [CNT_W-1:0] LAST_G = CNT_W'(GAP_CYC - 1);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 ready, accept, sweep_on;
  logic [NUM_TAPS-1:0]  slice, a_bus;

  assign s.s_ready = ready;
  assign accept    = s.s_valid && ready;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // One counter serves as bit index in SWEEP and as idle-cycle count in GAP.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SWEEP;
          cnt_nxt   = '0;
        end
      end
      SWEEP: begin
        if (cnt == LAST_B) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == LAST_G) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Reset gates every output low immediately, not just from the next edge.
  always_comb begin
    ready    = 1'b0;
    sweep_on = 1'b0;
    start    = 1'b0;
    last_bit = 1'b0;
    busy     = 1'b0;
    if (!reset) begin
      ready    = (state == IDLE);
      sweep_on = (state == SWEEP);
      start    = sweep_on && (cnt == '0);
      last_bit = sweep_on && (cnt == LAST_B);
      busy     = (state == SWEEP) || (state == GAP);
    end
  end

  da_tap_line #(
    .SAMPLE_W (SAMPLE_W)
  ) u_tap_line (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (accept),
    .clear     (clear_taps && (state == IDLE)),
    .load_data (s.s_data),
    .bit_sel   (cnt[BIT_W-1:0]),
    .slice     (slice)
  );

  assign a_bus = sweep_on ? slice : '0;
  assign A0 = a_bus[0*TAPS_PER_ROM +: TAPS_PER_ROM];
  assign A1 = a_bus[1*TAPS_PER_ROM +: TAPS_PER_ROM];
  assign A2 = a_bus[2*TAPS_PER_ROM +: TAPS_PER_ROM];
  assign A3 = a_bus[3*TAPS_PER_ROM +: TAPS_PER_ROM];
  assign A4 = a_bus[4*TAPS_PER_ROM +: TAPS_PER_ROM];
  assign A5 = a_bus[5*TAPS_PER_ROM +: TAPS_PER_ROM];
  assign A6 = a_bus[6*TAPS_PER_ROM +: TAPS_PER_ROM];
  assign A7 = a_bus[7*TAPS_PER_ROM +: TAPS_PER_ROM];

endmodule

// File: tb/tb_da_tap_feeder.sv
// Directed bench for da_tap_feeder: impulse, travel, sign, back-pressure, clear and reset cases.
module tb_da_tap_feeder;
  import da_pkg::*;

  localparam int SAMPLE_W = 8;
  localparam int GAP_CYC  = 3;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   reset;
  logic   clear_taps;
  logic [7:0] A7, A6, A5, A4, A3, A2, A1, A0;
  logic   start, last_bit, busy;
  state_t state_dbg;
  logic [63:0] a_all;
  int     cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  da_tap_feeder_if #(.SAMPLE_W(SAMPLE_W)) s_if ();

  da_tap_feeder #(
    .SAMPLE_W (SAMPLE_W),
    .GAP_CYC  (GAP_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear_taps (clear_taps),
    .s          (s_if.slave),
    .A7         (A7),
    .A6         (A6),
    .A5         (A5),
    .A4         (A4),
    .A3         (A3),
    .A2         (A2),
    .A1         (A1),
    .A0         (A0),
    .start      (start),
    .last_bit   (last_bit),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  assign a_all = {A7, A6, A5, A4, A3, A2, A1, A0};

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]  mtap [64];
  logic [63:0] cap_a [SAMPLE_W];
  logic [7:0]  cap_start, cap_last;
  logic [7:0]  bp_data [3] = '{8'h10, 8'h20, 8'h30};
  int          acc_cyc [3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_slice(input int b);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = mtap[i][b];
    return r;
  endfunction

  task automatic model_push(input logic [7:0] d, input logic clr);
    for (int i = 63; i > 0; i--) mtap[i] = clr ? 8'h00 : mtap[i-1];
    mtap[0] = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) mtap[i] = 8'h00;
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge in IDLE; returns at the negedge of sweep cycle b=0.
  task automatic send_sample(input logic [7:0] d, input logic clr);
    check("accept_ready", s_if.s_ready, 1'b1);
    s_if.s_data  = d;
    s_if.s_valid = 1'b1;
    clear_taps   = clr;
    @(negedge clk);
    s_if.s_valid = 1'b0;
    clear_taps   = 1'b0;
    model_push(d, clr);
  endtask

  // Checks one full frame from b=0; returns at the first IDLE negedge afterwards.
  task automatic run_frame();
    int ready_low;
    ready_low = 0;
    for (int b = 0; b < SAMPLE_W; b++) begin
      check($sformatf("sweep_a_b%0d", b), a_all, exp_slice(b));
      check($sformatf("sweep_flags_b%0d", b), {start, last_bit, busy},
            {(b == 0), (b == SAMPLE_W - 1), 1'b1});
      check("sweep_state", state_dbg, SWEEP);
      cap_a[b]     = a_all;
      cap_start[b] = start;
      cap_last[b]  = last_bit;
      if (!s_if.s_ready) ready_low++;
      @(negedge clk);
    end
    for (int g = 0; g < GAP_CYC; g++) begin
      check("gap_a", a_all, 64'h0);
      check("gap_flags", {start, last_bit, busy, state_dbg}, {3'b001, GAP});
      if (!s_if.s_ready) ready_low++;
      @(negedge clk);
    end
    check("idle_ready_busy", {s_if.s_ready, busy}, 2'b10);
    check("ready_low_cycles", ready_low, 11);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] acc;
    int n_acc, guard;
    reset        = 1'b1;
    clear_taps   = 1'b0;
    s_if.s_valid = 1'b0;
    s_if.s_data  = 8'h00;
    model_clear();

    repeat (3) @(negedge clk);
    check("rst_outputs", {s_if.s_ready, start, last_bit, busy}, 4'b0000);
    check("rst_a", a_all, 64'h0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", s_if.s_ready, 1'b1);
    check("post_rst_state", state_dbg, IDLE);

    // impulse
    send_sample(8'h01, 1'b0);
    run_frame();
    check("imp_b0", cap_a[0], 64'h01);
    check("imp_start", cap_start, 8'h01);
    check("imp_last", cap_last, 8'h80);
    acc = '0;
    for (int b = 1; b < SAMPLE_W; b++) acc |= cap_a[b];
    check("imp_b1_7", acc, 64'h0);

    // impulse travels through A0 into A1
    send_sample(8'h00, 1'b0);
    run_frame();
    check("travel_2nd", cap_a[0], 64'h02);
    for (int n = 0; n < 7; n++) begin
      send_sample(8'h00, 1'b0);
      run_frame();
    end
    check("travel_9th", cap_a[0], 64'h0100);

    // clear in IDLE without a sample
    clear_taps = 1'b1;
    @(negedge clk);
    clear_taps = 1'b0;
    model_clear();
    check("clr_idle_state", {s_if.s_ready, state_dbg}, {1'b1, IDLE});

    // negative sample: sign bit present on every plane
    send_sample(8'hFF, 1'b0);
    run_frame();
    for (int b = 0; b < SAMPLE_W; b++) check($sformatf("neg_b%0d", b), cap_a[b], 64'h01);
    check("neg_last", cap_last, 8'h80);

    // fill every tap with 0xFF
    for (int n = 0; n < 63; n++) begin
      send_sample(8'hFF, 1'b0);
      run_frame();
    end
    check("fill_b0", cap_a[0], {64{1'b1}});

    // clear + load in the same cycle
    send_sample(8'h01, 1'b1);
    run_frame();
    check("clrld_b0", cap_a[0], 64'h01);
    acc = '0;
    for (int b = 1; b < SAMPLE_W; b++) acc |= cap_a[b];
    check("clrld_b1_7", acc, 64'h0);

    // back-pressure: s_valid held high across three frames
    s_if.s_data  = bp_data[0];
    s_if.s_valid = 1'b1;
    n_acc = 0;
    guard = 0;
    while (n_acc < 3 && guard < 60) begin
      if (s_if.s_ready) begin
        acc_cyc[n_acc] = cyc;
        model_push(bp_data[n_acc], 1'b0);
        n_acc++;
      end
      @(negedge clk);
      guard++;
      if (n_acc < 3) s_if.s_data = bp_data[n_acc];
      else s_if.s_valid = 1'b0;
    end
    check("bp_accepts", n_acc, 3);
    if (n_acc == 3) begin
      check("bp_space_1", acc_cyc[1] - acc_cyc[0], 12);
      check("bp_space_2", acc_cyc[2] - acc_cyc[1], 12);
      run_frame();
      check("bp_b0", cap_a[0], 64'h08);
      check("bp_b4", cap_a[4], 64'h05);
      check("bp_b5", cap_a[5], 64'h03);
    end

    // reset in the middle of a sweep
    send_sample(8'hFF, 1'b0);
    repeat (4) @(negedge clk);
    check("mid_b4", a_all, exp_slice(4));
    reset = 1'b1;
    #1;
    check("rst_mid_a", a_all, 64'h0);
    check("rst_mid_flags", {s_if.s_ready, start, last_bit, busy}, 4'b0000);
    @(negedge clk);
    check("rst_mid_state", state_dbg, IDLE);
    check("rst_mid_ready", s_if.s_ready, 1'b0);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    check("rst_rel_out", {s_if.s_ready, start, last_bit, busy}, 4'b1000);
    check("rst_rel_a", a_all, 64'h0);
    send_sample(8'h00, 1'b0);
    run_frame();
    acc = '0;
    for (int b = 0; b < SAMPLE_W; b++) acc |= cap_a[b];
    check("rst_zero_taps", acc, 64'h0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
